// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions: NOP encoding, default reset PC, fetch FSM states.
package fetch_stage_pkg;

  // addi x0,x0,0 -- the canonical bubble instruction.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // Default program counter after reset (4-byte aligned).
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch control states.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Parameterised pipeline register between two stages: carries pc, pc+4,
// an instruction word and a valid bit. Kill wins over load; kill leaves the
// pc fields untouched and replaces the instruction with a NOP bubble.
module if_id_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            kill,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] next_pc4,
  input  logic [31:0]     next_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [31:0]     instr,
  output logic            valid
);

  // Register update: kill > load > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      pc4   <= RESET_PC + XLEN'(4);
      instr <= NOP;
      valid <= 1'b0;
    end else if (kill) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= next_pc;
      pc4   <= next_pc4;
      instr <= next_instr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: program counter, RUN/HALTED control and the
// IF/ID pipeline register. Priority in RUN: halt > flush > stall > advance.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter logic [31:0]     NOP      = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            halted,
  output logic            misaligned
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            ifid_load;
  logic            ifid_kill;
  logic            misaligned_set;

  // Wraps modulo 2^XLEN naturally.
  assign pc_plus4  = pc + XLEN'(4);
  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state, next PC and IF/ID control. A flush kills the slot even when
  // stall is also high, so a dead instruction is never held in IF/ID.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    ifid_load      = 1'b0;
    ifid_kill      = 1'b0;
    misaligned_set = 1'b0;
    case (state)
      RUN: begin
        if (halt) begin
          state_next = HALTED;
          ifid_kill  = 1'b1;
        end else if (flush) begin
          pc_next        = {redirect_pc[XLEN-1:2], 2'b00};
          ifid_kill      = 1'b1;
          misaligned_set = |redirect_pc[1:0];
        end else if (!stall) begin
          pc_next   = pc_plus4;
          ifid_load = 1'b1;
        end
      end
      HALTED: begin
        // Frozen until reset; all requests ignored.
      end
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned <= 1'b0;
    end else if (misaligned_set) begin
      misaligned <= 1'b1;
    end
  end

  if_id_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load),
    .kill       (ifid_kill),
    .next_pc    (pc),
    .next_pc4   (pc_plus4),
    .next_instr (imem_rdata),
    .pc         (if_id_pc),
    .pc4        (if_id_pc4),
    .instr      (if_id_instr),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural model feeding a scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOPW    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        misaligned;

  int unsigned compared = 0;
  int unsigned failed   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid, m_halted, m_mis;

  // Saved IF/ID snapshot for stall checks.
  logic [31:0] s_pc, s_pc4, s_instr;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ MEM_KEY;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .NOP      (NOPW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .misaligned  (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.addr   = m_pc;
    e.pc     = m_ipc;
    e.pc4    = m_ipc4;
    e.instr  = m_instr;
    e.valid  = m_valid;
    e.halted = m_halted;
    e.mis    = m_mis;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    compared++;
    assert (sb.size() != 0) else begin
      failed++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".addr"},   imem_addr,   e.addr);
      chk({tag, ".pc"},     if_id_pc,    e.pc);
      chk({tag, ".pc4"},    if_id_pc4,   e.pc4);
      chk({tag, ".instr"},  if_id_instr, e.instr);
      chk({tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, e.valid});
      chk({tag, ".halted"}, {31'd0, halted},      {31'd0, e.halted});
      chk({tag, ".mis"},    {31'd0, misaligned},  {31'd0, e.mis});
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_ipc    = 32'h0;
    m_ipc4   = 32'h4;
    m_instr  = NOPW;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_mis    = 1'b0;
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    if (!m_halted) begin
      if (halt) begin
        m_halted = 1'b1;
        m_valid  = 1'b0;
        m_instr  = NOPW;
      end else if (flush) begin
        m_valid = 1'b0;
        m_instr = NOPW;
        if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (!stall) begin
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 32'd4;
        m_instr = m_pc ^ MEM_KEY;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  // One clock edge; inputs are stable, outputs sampled 1 time unit after.
  task automatic cycle(input string tag);
    model_step();
    push_model();
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  // Asynchronous reset applied between edges, checked before any edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    push_model();
    #2;
    pop_compare(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_in(input logic s, input logic f, input logic h, input logic [31:0] r);
    stall = s;
    flush = f;
    halt = h;
    redirect_pc = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);
    #1;

    // Reset then run.
    do_reset("reset");
    chk("reset.addr", imem_addr, 32'h0);
    chk("reset.pc4", if_id_pc4, 32'h4);
    chk("reset.instr", if_id_instr, NOPW);
    set_in(0, 0, 0, '0);
    cycle("run0");
    chk("run0.ifid_pc", if_id_pc, 32'h0);
    chk("run0.ifid_instr", if_id_instr, 32'hA5A5_0000);
    chk("run0.valid", {31'd0, if_id_valid}, 32'd1);
    chk("run0.addr", imem_addr, 32'h4);
    cycle("run1");
    chk("run1.addr", imem_addr, 32'h8);
    cycle("run2");
    cycle("run3");
    chk("pre_stall.addr", imem_addr, 32'h10);

    // Stall for 3 cycles at PC=0x10.
    s_pc = if_id_pc; s_pc4 = if_id_pc4; s_instr = if_id_instr;
    set_in(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.addr", imem_addr, 32'h10);
      chk("stall.ifid_pc", if_id_pc, s_pc);
      chk("stall.ifid_pc4", if_id_pc4, s_pc4);
      chk("stall.ifid_instr", if_id_instr, s_instr);
    end
    set_in(0, 0, 0, '0);
    cycle("unstall");
    chk("unstall.addr", imem_addr, 32'h14);

    // Flush over stall.
    set_in(1, 1, 0, 32'h200);
    cycle("flush_stall");
    chk("flush_stall.addr", imem_addr, 32'h200);
    chk("flush_stall.valid", {31'd0, if_id_valid}, 32'd0);
    chk("flush_stall.instr", if_id_instr, NOPW);
    set_in(0, 0, 0, '0);
    cycle("after_flush");
    chk("after_flush.pc", if_id_pc, 32'h200);
    chk("after_flush.valid", {31'd0, if_id_valid}, 32'd1);

    // Misaligned redirect, sticky across 10 cycles, cleared by reset.
    set_in(0, 1, 0, 32'h102);
    cycle("mis_redirect");
    chk("mis.addr", imem_addr, 32'h100);
    chk("mis.flag", {31'd0, misaligned}, 32'd1);
    set_in(0, 0, 0, '0);
    for (int i = 0; i < 10; i++) cycle("mis_run");
    chk("mis.sticky", {31'd0, misaligned}, 32'd1);
    do_reset("mis_reset");
    chk("mis.cleared", {31'd0, misaligned}, 32'd0);

    // Wrap-around.
    set_in(0, 1, 0, 32'hFFFF_FFFC);
    cycle("wrap_redirect");
    set_in(0, 0, 0, '0);
    cycle("wrap_run");
    chk("wrap.pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", if_id_pc4, 32'h0);
    chk("wrap.addr", imem_addr, 32'h0);
    cycle("wrap_next");
    chk("wrap_next.pc", if_id_pc, 32'h0);

    // Halt at PC=0x40 with later flush/stall pulses ignored.
    set_in(0, 1, 0, 32'h40);
    cycle("to_40");
    set_in(0, 1, 1, 32'h80);
    cycle("halt");
    chk("halt.halted", {31'd0, halted}, 32'd1);
    chk("halt.addr", imem_addr, 32'h40);
    chk("halt.valid", {31'd0, if_id_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_in(i[0], 1, 0, 32'h80 + 32'(i * 4));
      cycle("halted_flush");
      set_in(0, 0, 0, '0);
      cycle("halted_idle");
    end
    chk("halted.addr", imem_addr, 32'h40);
    do_reset("halt_reset");
    chk("halt_reset.addr", imem_addr, 32'h0);
    chk("halt_reset.halted", {31'd0, halted}, 32'd0);
    set_in(0, 0, 0, '0);
    cycle("post_reset");
    chk("post_reset.pc", if_id_pc, 32'h0);
    chk("post_reset.instr", if_id_instr, 32'hA5A5_0000);

    // Mid-cycle asynchronous reset during normal running.
    cycle("run_a");
    cycle("run_b");
    do_reset("async_reset");

    chk("scoreboard.drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the RISC-V pipelined processor. Holds the program counter and the IF/ID pipeline register. Each cycle it presents the fetch address to instruction memory and captures the returned instruction, PC, and PC+4 into IF/ID for the decode stage. It obeys stall and flush/redirect requests from the hazard and branch logic, and stops fetching on a halt request from later stages.

## Interface
- `XLEN`, 32: address and data width.
- `RESET_PC`, 0: PC value after reset. Must be 4-byte aligned.
- `NOP`, 32'h0000_0013: instruction word IF/ID holds when its slot is invalid (`addi x0,x0,0`).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard unit request to hold PC and IF/ID.
- `flush` in 1: taken branch/jump resolved downstream; redirect the PC and kill the IF/ID slot.
- `redirect_pc` in XLEN: target address, used only when `flush`=1.
- `halt` in 1: ecall/ebreak reached a later stage; stop fetching.
- `imem_addr` out XLEN: fetch address. Always equals the PC register.
- `imem_rdata` in 32: instruction at `imem_addr`, combinational, valid in the same cycle.
- `if_id_pc` out XLEN: PC of the captured instruction.
- `if_id_pc4` out XLEN: `if_id_pc`+4.
- `if_id_instr` out 32: captured instruction, or `NOP` when invalid.
- `if_id_valid` out 1: IF/ID slot holds a real instruction.
- `halted` out 1: high while the FSM is in HALTED.
- `misaligned` out 1: sticky flag. Set when a redirect target has `redirect_pc[1:0]`≠0.

## Operation
- FSM states: RUN and HALTED. Reset enters RUN.
- RUN priority per cycle, highest first:
  1. `halt`: go to HALTED. PC holds. IF/ID is loaded invalid (`valid`=0, `instr`=`NOP`, pc fields hold).
  2. `flush`: PC ← `{redirect_pc[XLEN-1:2],2'b00}`. IF/ID is loaded invalid. If `redirect_pc[1:0]`≠0, set `misaligned`.
  3. `stall`: PC and all IF/ID fields hold their values.
  4. Otherwise: PC ← PC+4. IF/ID ← {PC, PC+4, `imem_rdata`, valid=1}.
- Flush overrides stall in the same cycle: a killed slot is never held.
- HALTED: PC and IF/ID are frozen with `valid`=0. `stall`, `flush`, and `halt` are ignored. The only exit is `rst`.
- PC arithmetic is modulo 2^XLEN. PC+4 from 0xFFFF_FFFC wraps to 0x0000_0000, and `if_id_pc4` wraps the same way.
- `misaligned` is informational only. Fetch continues from the aligned address. The flag clears only on reset.

## Timing
- Reset values:
  - PC = `imem_addr` = `RESET_PC`
  - `if_id_pc` = `RESET_PC`
  - `if_id_pc4` = `RESET_PC`+4
  - `if_id_instr` = `NOP`
  - `if_id_valid` = 0
  - `halted` = 0
  - `misaligned` = 0
- Fetch-to-decode latency is 1 cycle. An instruction read in cycle N appears on the IF/ID outputs after edge N+1.
- Redirect penalty: the flush edge loads the target into PC and a bubble into IF/ID. The target instruction is valid in IF/ID one edge later.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of `clk`. The first fetch after deassertion is from `RESET_PC`.
- Stall held for K cycles: `imem_addr` is constant for K cycles and IF/ID outputs are bit-identical across them.
- `halted` rises on the edge that samples `halt`=1 in RUN.

## Structure
- The shared processor package holds the `NOP` encoding, `RESET_PC` default, and the FSM state encoding (RUN=1'b0, HALTED=1'b1).
- One sub-module is natural: `if_id_reg`, a parameterised pipeline register with load and kill inputs. It is instantiated once here and reused by the later pipeline stages. The PC register and FSM stay inline.

## Test plan
- **Reset then run:** `rst` pulse, `RESET_PC`=0, memory returns `addr`^0xA5A5_0000 -> `imem_addr` reads 0, 4, 8. IF/ID shows pc=0, instr=0xA5A5_0000, valid=1 after the first edge.
- **Stall:** 3-cycle `stall` at PC=0x10 -> `imem_addr` stays 0x10 and IF/ID is unchanged for 3 cycles. PC=0x14 one edge after `stall` drops.
- **Flush over stall:** `flush`=1, `stall`=1, `redirect_pc`=0x200 -> next PC=0x200, `if_id_valid`=0, `if_id_instr`=0x0000_0013. The following edge gives IF/ID pc=0x200, valid=1.
- **Misaligned redirect:** `redirect_pc`=0x102 -> PC=0x100 and `misaligned`=1. The flag remains 1 after 10 more cycles, and clears on `rst`.
- **Halt:** `halt` at PC=0x40, with `flush` pulses afterwards -> `halted`=1, PC stays 0x40, `valid`=0. Asserting `rst` returns PC to `RESET_PC` with `halted`=0.
- **Wrap-around:** `redirect_pc`=0xFFFF_FFFC, then run -> IF/ID pc=0xFFFF_FFFC with pc4=0x0000_0000. The next fetch is from address 0.
